// File: rtl/ext_bus_pkg.sv
// Shared types and constants for the external asynchronous bus initiator.
package ext_bus_pkg;

    localparam int PHASE_W = 4;
    localparam int WAIT_W  = 8;

    localparam int DEF_SETUP_CYC  = 1;
    localparam int DEF_STROBE_CYC = 2;
    localparam int DEF_HOLD_CYC   = 1;
    localparam int DEF_WAIT_MAX   = 255;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_WAIT,
        ST_HOLD,
        ST_DONE
    } bus_state_e;

    // Active-low strobe levels during the strobe phase, packed as {rdn, wr1n, wr0n}.
    function automatic logic [2:0] strobe_levels(input logic we, input logic [1:0] be);
        return we ? {1'b1, ~be[1], ~be[0]} : 3'b011;
    endfunction

endpackage

// File: rtl/ext_bus_ctrl_if.sv
// Core-side request/acknowledge channel of the external bus initiator.
interface ext_bus_ctrl_if;
    import ext_bus_pkg::*;

    logic        REQ;
    logic        WE;
    logic [1:0]  BE;
    logic [15:0] ADDR;
    logic [15:0] WDATA;
    logic [15:0] RDATA;
    logic        ACK;
    logic        ERR;
    logic        BUSY;

    modport master (
        output REQ, WE, BE, ADDR, WDATA,
        input  RDATA, ACK, ERR, BUSY
    );

    modport slave (
        input  REQ, WE, BE, ADDR, WDATA,
        output RDATA, ACK, ERR, BUSY
    );

endinterface

// File: rtl/ext_bus_ctrl_sync2.sv
// Two-flop synchroniser for asynchronous board inputs; flops reset to RESET_VAL.
module sync2 #(
    parameter int   WIDTH     = 1,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            meta_reg <= {WIDTH{RESET_VAL}};
            sync_reg <= {WIDTH{RESET_VAL}};
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/ext_bus_ctrl.sv
// CPU-side initiator turning a single REQ/ACK transaction into a timed read or
// write cycle on the off-chip 16-bit asynchronous bus; every pin is a flop output.
module ext_bus_ctrl
    import ext_bus_pkg::*;
#(
    parameter int SETUP_CYC  = DEF_SETUP_CYC,
    parameter int STROBE_CYC = DEF_STROBE_CYC,
    parameter int HOLD_CYC   = DEF_HOLD_CYC,
    parameter int WAIT_MAX   = DEF_WAIT_MAX
) (
    input  logic          CLK,
    input  logic          RESETN,
    ext_bus_ctrl_if.slave core,
    output logic [15:0]   PIN_ADDR,
    output logic [15:0]   PIN_DBUS_O,
    output logic          PIN_DBUS_OE,
    input  logic [15:0]   PIN_DBUS_I,
    output logic          PIN_RDN,
    output logic          PIN_WR0N,
    output logic          PIN_WR1N,
    input  logic          PIN_WAITN
);

    localparam logic [PHASE_W-1:0] SETUP_LAST  = PHASE_W'((SETUP_CYC  > 0) ? SETUP_CYC  - 1 : 0);
    localparam logic [PHASE_W-1:0] STROBE_LAST = PHASE_W'((STROBE_CYC > 0) ? STROBE_CYC - 1 : 0);
    localparam logic [PHASE_W-1:0] HOLD_LAST   = PHASE_W'((HOLD_CYC   > 0) ? HOLD_CYC   - 1 : 0);
    localparam logic [WAIT_W-1:0]  WAIT_LAST   = WAIT_W'((WAIT_MAX    > 0) ? WAIT_MAX   - 1 : 0);

    bus_state_e         state_reg,    state_next;
    logic [PHASE_W-1:0] phase_reg,    phase_next;
    logic [WAIT_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic               we_reg,       we_next;
    logic [1:0]         be_reg,       be_next;
    logic               timeout_reg,  timeout_next;
    logic [15:0]        addr_reg,     addr_next;
    logic [15:0]        dout_reg,     dout_next;
    logic               oe_reg,       oe_next;
    logic [2:0]         strobe_reg,   strobe_next;
    logic [15:0]        rdata_reg,    rdata_next;
    logic               ack_reg,      ack_next;
    logic               err_reg,      err_next;
    logic               busy_reg,     busy_next;

    logic waitn_sync;
    logic leave_strobe;
    logic abort;
    logic enter_done;

    sync2 #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_waitn_sync (
        .CLK    (CLK),
        .RESETN (RESETN),
        .d      (PIN_WAITN),
        .q      (waitn_sync)
    );

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_reg    <= ST_IDLE;
            phase_reg    <= '0;
            wait_cnt_reg <= '0;
            we_reg       <= 1'b0;
            be_reg       <= 2'b00;
            timeout_reg  <= 1'b0;
            addr_reg     <= '0;
            dout_reg     <= '0;
            oe_reg       <= 1'b0;
            strobe_reg   <= 3'b111;
            rdata_reg    <= '0;
            ack_reg      <= 1'b0;
            err_reg      <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            phase_reg    <= phase_next;
            wait_cnt_reg <= wait_cnt_next;
            we_reg       <= we_next;
            be_reg       <= be_next;
            timeout_reg  <= timeout_next;
            addr_reg     <= addr_next;
            dout_reg     <= dout_next;
            oe_reg       <= oe_next;
            strobe_reg   <= strobe_next;
            rdata_reg    <= rdata_next;
            ack_reg      <= ack_next;
            err_reg      <= err_next;
            busy_reg     <= busy_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        phase_next    = phase_reg;
        wait_cnt_next = wait_cnt_reg;
        we_next       = we_reg;
        be_next       = be_reg;
        timeout_next  = timeout_reg;
        addr_next     = addr_reg;
        dout_next     = dout_reg;
        oe_next       = oe_reg;
        strobe_next   = strobe_reg;
        rdata_next    = rdata_reg;
        ack_next      = 1'b0;
        err_next      = 1'b0;
        busy_next     = busy_reg;
        leave_strobe  = 1'b0;
        abort         = 1'b0;
        enter_done    = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                if (core.REQ) begin
                    we_next      = core.WE;
                    be_next      = core.BE;
                    addr_next    = core.ADDR;
                    dout_next    = core.WDATA;
                    oe_next      = core.WE;
                    busy_next    = 1'b1;
                    timeout_next = 1'b0;
                    phase_next   = '0;
                    if (SETUP_CYC == 0) begin
                        state_next  = ST_STROBE;
                        strobe_next = strobe_levels(core.WE, core.BE);
                    end else begin
                        state_next  = ST_SETUP;
                    end
                end
            end

            ST_SETUP: begin
                if (phase_reg == SETUP_LAST) begin
                    state_next  = ST_STROBE;
                    phase_next  = '0;
                    strobe_next = strobe_levels(we_reg, be_reg);
                end else begin
                    phase_next  = phase_reg + 1'b1;
                end
            end

            ST_STROBE: begin
                if (phase_reg == STROBE_LAST) begin
                    if (!waitn_sync) begin
                        state_next    = ST_WAIT;
                        wait_cnt_next = '0;
                    end else begin
                        leave_strobe  = 1'b1;
                    end
                end else begin
                    phase_next = phase_reg + 1'b1;
                end
            end

            // A release seen on the final wait cycle still completes normally.
            ST_WAIT: begin
                if (waitn_sync) begin
                    leave_strobe = 1'b1;
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    leave_strobe = 1'b1;
                    abort        = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end

            ST_HOLD: begin
                if (phase_reg == HOLD_LAST) begin
                    enter_done = 1'b1;
                end else begin
                    phase_next = phase_reg + 1'b1;
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
                busy_next  = 1'b0;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (leave_strobe) begin
            strobe_next  = 3'b111;
            timeout_next = abort;
            phase_next   = '0;
            if (!abort && !we_reg) begin
                rdata_next = PIN_DBUS_I;
            end
            if (HOLD_CYC == 0) begin
                enter_done = 1'b1;
            end else begin
                state_next = ST_HOLD;
            end
        end

        if (enter_done) begin
            state_next = ST_DONE;
            ack_next   = 1'b1;
            err_next   = timeout_next;
            oe_next    = 1'b0;
        end
    end

    assign PIN_ADDR    = addr_reg;
    assign PIN_DBUS_O  = dout_reg;
    assign PIN_DBUS_OE = oe_reg;
    assign PIN_RDN     = strobe_reg[2];
    assign PIN_WR1N    = strobe_reg[1];
    assign PIN_WR0N    = strobe_reg[0];

    assign core.RDATA  = rdata_reg;
    assign core.ACK    = ack_reg;
    assign core.ERR    = err_reg;
    assign core.BUSY   = busy_reg;

endmodule

// File: tb/tb_ext_bus_ctrl.sv
// Directed bench for ext_bus_ctrl: per-cycle pin checks against the timing formula
// and a scoreboard of expected ACK cycle / RDATA / ERR popped at each ACK.
module tb_ext_bus_ctrl;
    import ext_bus_pkg::*;

    localparam int S           = DEF_SETUP_CYC;
    localparam int T           = DEF_STROBE_CYC;
    localparam int H           = DEF_HOLD_CYC;
    localparam int TO_WAIT_MAX = 4;

    logic        CLK    = 1'b0;
    logic        RESETN = 1'b1;
    logic [15:0] din    = 16'h0000;
    logic        waitn_a = 1'b1;
    logic        waitn_b = 1'b1;

    ext_bus_ctrl_if bus_a ();
    ext_bus_ctrl_if bus_b ();

    logic [15:0] addr_a, dout_a, addr_b, dout_b;
    logic        oe_a, rdn_a, wr0n_a, wr1n_a;
    logic        oe_b, rdn_b, wr0n_b, wr1n_b;

    ext_bus_ctrl u_dut (
        .CLK         (CLK),
        .RESETN      (RESETN),
        .core        (bus_a),
        .PIN_ADDR    (addr_a),
        .PIN_DBUS_O  (dout_a),
        .PIN_DBUS_OE (oe_a),
        .PIN_DBUS_I  (din),
        .PIN_RDN     (rdn_a),
        .PIN_WR0N    (wr0n_a),
        .PIN_WR1N    (wr1n_a),
        .PIN_WAITN   (waitn_a)
    );

    ext_bus_ctrl #(.WAIT_MAX(TO_WAIT_MAX)) u_dut_to (
        .CLK         (CLK),
        .RESETN      (RESETN),
        .core        (bus_b),
        .PIN_ADDR    (addr_b),
        .PIN_DBUS_O  (dout_b),
        .PIN_DBUS_OE (oe_b),
        .PIN_DBUS_I  (din),
        .PIN_RDN     (rdn_b),
        .PIN_WR0N    (wr0n_b),
        .PIN_WR1N    (wr1n_b),
        .PIN_WAITN   (waitn_b)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          ack_cyc;
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] rdata_model_a = 16'h0000;
    logic [15:0] rdata_model_b = 16'h0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // wait_rel: 0 = no wait, >0 = WAITN low from cycle 1 and released after that many cycles,
    // <0 = WAITN held low for the whole transaction (timeout).
    task automatic run_txn(input bit sel, input string tag, input logic we, input logic [1:0] be,
                           input logic [15:0] addr, input logic [15:0] wdata, input logic [15:0] rdin,
                           input int wait_rel, input bit keep_req);
        int   w;
        int   d;
        bit   timeout;
        bit   got;
        bit   in_strobe;
        exp_t e;
        exp_t p;
        logic o_rdn, o_wr0n, o_wr1n, o_oe, o_busy, o_ack, o_err;
        logic [15:0] o_addr, o_dout, o_rdata;

        timeout = (wait_rel < 0);
        w = timeout ? TO_WAIT_MAX : ((wait_rel > 0) ? (wait_rel + 3 - (S + T)) : 0);
        d = 1 + S + T + H + w;
        if (!we && !timeout) begin
            if (sel) rdata_model_b = rdin;
            else     rdata_model_a = rdin;
        end
        e.ack_cyc = d;
        e.rdata   = sel ? rdata_model_b : rdata_model_a;
        e.err     = timeout;
        sb_q.push_back(e);

        din = rdin;
        if (sel) begin
            bus_b.REQ = 1'b1; bus_b.WE = we; bus_b.BE = be; bus_b.ADDR = addr; bus_b.WDATA = wdata;
        end else begin
            bus_a.REQ = 1'b1; bus_a.WE = we; bus_a.BE = be; bus_a.ADDR = addr; bus_a.WDATA = wdata;
        end

        got = 1'b0;
        p   = e;
        for (int k = 1; k <= d + 20 && !got; k++) begin
            @(posedge CLK);
            #1;
            if (wait_rel != 0 && k == 1) begin
                if (sel) waitn_b = 1'b0; else waitn_a = 1'b0;
            end
            if (wait_rel > 0 && k == wait_rel + 1) begin
                if (sel) waitn_b = 1'b1; else waitn_a = 1'b1;
            end
            o_rdn   = sel ? rdn_b  : rdn_a;
            o_wr0n  = sel ? wr0n_b : wr0n_a;
            o_wr1n  = sel ? wr1n_b : wr1n_a;
            o_oe    = sel ? oe_b   : oe_a;
            o_addr  = sel ? addr_b : addr_a;
            o_dout  = sel ? dout_b : dout_a;
            o_busy  = sel ? bus_b.BUSY  : bus_a.BUSY;
            o_ack   = sel ? bus_b.ACK   : bus_a.ACK;
            o_err   = sel ? bus_b.ERR   : bus_a.ERR;
            o_rdata = sel ? bus_b.RDATA : bus_a.RDATA;

            in_strobe = (k >= S + 1) && (k <= S + T + w);
            chk($sformatf("%s c%0d RDN", tag, k),  o_rdn,  !(in_strobe && !we));
            chk($sformatf("%s c%0d WR0N", tag, k), o_wr0n, !(in_strobe && we && be[0]));
            chk($sformatf("%s c%0d WR1N", tag, k), o_wr1n, !(in_strobe && we && be[1]));
            chk($sformatf("%s c%0d OE", tag, k),   o_oe,   we && (k <= S + T + w + H));
            chk($sformatf("%s c%0d BUSY", tag, k), o_busy, 1'b1);
            if (k == 1) begin
                chk($sformatf("%s ADDR", tag), o_addr, addr);
                if (we) chk($sformatf("%s DOUT", tag), o_dout, wdata);
            end
            if (o_ack) begin
                got = 1'b1;
                p = sb_q.pop_front();
                chk($sformatf("%s ACK cycle", tag), k, p.ack_cyc);
                chk($sformatf("%s RDATA", tag), o_rdata, p.rdata);
                chk($sformatf("%s ERR", tag), o_err, p.err);
            end
        end
        if (!got) begin
            chk($sformatf("%s ACK seen", tag), got, 1'b1);
            void'(sb_q.pop_front());
        end

        if (!keep_req) begin
            if (sel) bus_b.REQ = 1'b0; else bus_a.REQ = 1'b0;
        end
        if (sel) waitn_b = 1'b1; else waitn_a = 1'b1;

        @(posedge CLK);
        #1;
        chk($sformatf("%s idle BUSY", tag), sel ? bus_b.BUSY : bus_a.BUSY, 1'b0);
        chk($sformatf("%s idle ACK", tag),  sel ? bus_b.ACK  : bus_a.ACK,  1'b0);
        $display("txn %s dut=%0d we=%0d be=%b addr=%h expected_ack_cycle=%0d rdata_exp=%h err_exp=%0d",
                 tag, sel, we, be, addr, d, e.rdata, e.err);
    endtask

    initial begin
        bus_a.REQ = 1'b0; bus_a.WE = 1'b0; bus_a.BE = 2'b00; bus_a.ADDR = '0; bus_a.WDATA = '0;
        bus_b.REQ = 1'b0; bus_b.WE = 1'b0; bus_b.BE = 2'b00; bus_b.ADDR = '0; bus_b.WDATA = '0;

        #1 RESETN = 1'b0;
        #2;
        chk("reset PIN_ADDR", addr_a, 16'h0000);
        chk("reset PIN_DBUS_O", dout_a, 16'h0000);
        chk("reset OE", oe_a, 1'b0);
        chk("reset RDN", rdn_a, 1'b1);
        chk("reset WR0N", wr0n_a, 1'b1);
        chk("reset WR1N", wr1n_a, 1'b1);
        chk("reset RDATA", bus_a.RDATA, 16'h0000);
        chk("reset ACK", bus_a.ACK, 1'b0);
        chk("reset ERR", bus_a.ERR, 1'b0);
        chk("reset BUSY", bus_a.BUSY, 1'b0);
        $display("txn reset checked");
        #20;
        @(negedge CLK);
        RESETN = 1'b1;
        @(posedge CLK);
        #1;

        run_txn(1'b0, "wr_full",  1'b1, 2'b11, 16'h1234, 16'hBEEF, 16'h0000, 0, 1'b0);
        run_txn(1'b0, "wr_hi",    1'b1, 2'b10, 16'h1236, 16'hA500, 16'h0000, 0, 1'b0);
        run_txn(1'b0, "wr_none",  1'b1, 2'b00, 16'h1238, 16'h1111, 16'h0000, 0, 1'b0);
        run_txn(1'b0, "rd",       1'b0, 2'b00, 16'h0040, 16'h0000, 16'h5AA5, 0, 1'b0);
        run_txn(1'b0, "wr_after", 1'b1, 2'b01, 16'h0042, 16'h00C7, 16'hFFFF, 0, 1'b0);
        run_txn(1'b0, "rd_wait",  1'b0, 2'b11, 16'h0080, 16'h0000, 16'h0F0F, 6, 1'b0);

        run_txn(1'b1, "rd_pre",   1'b0, 2'b00, 16'h0100, 16'h0000, 16'h1357, 0, 1'b0);
        run_txn(1'b1, "rd_tmo",   1'b0, 2'b00, 16'h0102, 16'h0000, 16'hFFFF, -1, 1'b0);

        // Reset asserted mid-strobe of a write must release the pins without a clock edge.
        bus_a.REQ = 1'b1; bus_a.WE = 1'b1; bus_a.BE = 2'b11; bus_a.ADDR = 16'h2222; bus_a.WDATA = 16'h3333;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("rst_mid WR0N in strobe", wr0n_a, 1'b0);
        RESETN = 1'b0;
        #1;
        chk("rst_mid WR0N", wr0n_a, 1'b1);
        chk("rst_mid WR1N", wr1n_a, 1'b1);
        chk("rst_mid OE", oe_a, 1'b0);
        chk("rst_mid BUSY", bus_a.BUSY, 1'b0);
        bus_a.REQ = 1'b0;
        rdata_model_a = 16'h0000;
        rdata_model_b = 16'h0000;
        @(negedge CLK);
        RESETN = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge CLK); #1;
            chk($sformatf("rst_mid no ACK c%0d", i), bus_a.ACK, 1'b0);
        end
        $display("txn rst_mid write aborted by reset");

        run_txn(1'b0, "b2b_1", 1'b0, 2'b00, 16'h0200, 16'h0000, 16'hC3C3, 0, 1'b1);
        run_txn(1'b0, "b2b_2", 1'b0, 2'b00, 16'h0202, 16'h0000, 16'h3C3C, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
